dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle data-memory responder for the P5/P6 MIPS pipeline: the slave side of the memory-access interface driven by the M stage. It accepts one load/store request at a time over a Req/Ready handshake and performs the access after a fixed latency. Stores do byte/halfword merging; loads do sign/zero extension. Each response is reported with a one-cycle RValid pulse, and committed stores produce a PC-tagged write log for the course checker.

## Interface
- ADDR_WIDTH, 12, word-index width; memory holds 2^ADDR_WIDTH 32-bit words
- LATENCY, 2, edges from acceptance to response register load; legal range 1..15
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset; synchronous, active-high; clears state and all memory words
- Req  in  1  request valid; sampled only while Ready=1
- Wr  in  1  1=store, 0=load
- Op  in  3  0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed, 5-7 reserved
- Addr  in  32  byte address; word index = Addr[ADDR_WIDTH+1:2], upper bits ignored
- WData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- WPC  in  32  PC of the requesting instruction, used for logging
- Ready  out  1  responder idle and able to accept
- RValid  out  1  one-cycle response pulse
- RData  out  32  load result (extended); 0 for stores and errors
- Err  out  1  valid with RValid; misaligned access or reserved Op
- LogValid  out  1  one-cycle pulse on a committed store
- LogPC, LogAddr, LogData  out  32 each  WPC, word-aligned Addr ({Addr[31:2],2'b00}), and full merged word written

## Operation
- States: IDLE, BUSY, RESP. Reset state: IDLE. Reset values: Ready=1; RValid=Err=LogValid=0; RData=LogPC=LogAddr=LogData=0; counter=0.
- IDLE: Ready=1. At an edge where Req=1, latch Wr, Op, Addr, WData, WPC, load counter with LATENCY-1, and go to BUSY.
- BUSY: Ready=0. Decrement the counter each edge. At the edge where counter=0, execute the access, register the outputs, and go to RESP.
- RESP: RValid=1 for exactly one cycle, then IDLE at the next edge.
- Req is ignored while Ready=0. There is no queueing; the requester must hold or reissue Req.
- Alignment: word needs Addr[1:0]=0; half needs Addr[0]=0; byte is always aligned. A misaligned access or reserved Op sets Err=1 and RData=0, leaves memory unchanged, and keeps LogValid=0.
- Store merge: byte lane = Addr[1:0], half lane = Addr[1]. Only the addressed lanes change; the other bytes of the word are preserved. LogData is the resulting full word.
- Load extraction: select the lane as for stores. Ops 1/3 zero-extend; ops 2/4 sign-extend from bit 15 or bit 7.
- Memory is written only at the execute edge. A load in the same request sees the memory contents from before that edge.

## Timing
- Acceptance edge t0 (Req=1, Ready=1). Ready is low from t0 until edge t0+LATENCY+1.
- Memory commit and output register load happen at edge t0+LATENCY.
- RValid, RData, Err and LogValid/Log* are valid during the cycle between edges t0+LATENCY and t0+LATENCY+1.
- Ready returns high after t0+LATENCY+1, so a new request can be accepted at edge t0+LATENCY+2. Maximum throughput is one access per LATENCY+2 cycles.
- Rst has priority over everything at any edge:
  - an in-flight request is aborted with no memory write, no RValid and no log;
  - Req asserted in the same cycle as Rst is not accepted.
- Counter width is 4 bits. LATENCY=1 means BUSY lasts exactly one edge (counter starts at 0).
- The log fields hold their values between pulses; only LogValid pulses.

## Test plan
- After Rst, with LATENCY=2: store word 0x12345678 to Addr 0x10 with WPC 0x3000, Req at edge t0.
  - Ready=0 at t0+1; RValid=1 and LogValid=1 after t0+2.
  - LogPC=0x3000, LogAddr=0x10, LogData=0x12345678, Err=0; Ready=1 after t0+3.
- Byte store 0xAB to 0x13, then load op 4 from 0x13 → RData=0xFFFFFFAB. Load op 3 → 0x000000AB. Load word 0x10 → 0xAB345678.
- Half store 0x8001 to 0x12 → LogData=0x80015678. Load op 2 from 0x12 → 0xFFFF8001; op 1 → 0x00008001.
- Misalignment and reserved Op:
  - word store to 0x11 → Err=1, LogValid=0, and word 0x10 unchanged on readback;
  - half load at 0x13 → Err=1, RData=0;
  - Op=6 → Err=1.
- Req held high continuously for 3 distinct requests → exactly 3 RValid pulses, spaced LATENCY+2 cycles apart. A Req toggled only while Ready=0 is ignored, with no extra pulse.
- Rst asserted one cycle after acceptance of a store to 0x20 → no RValid, no LogValid, and a later load of 0x20 returns 0. Req together with Rst → not accepted, Ready=1 the next cycle.

Source files
------------

// File: rtl/dm_responder.sv
// ============================================================================
// Module   : dm_responder
// Purpose  : Fixed-latency data-memory slave for the MIPS M stage. It merges
//            byte/halfword stores, extends loads, and logs committed stores.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        Wr,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [31:0] WPC,
    output logic        Ready,
    output logic        RValid,
    output logic [31:0] RData,
    output logic        Err,
    output logic        LogValid,
    output logic [31:0] LogPC,
    output logic [31:0] LogAddr,
    output logic [31:0] LogData
);

    localparam int         c_depth    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_lat_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wpc;
    logic [31:0] r_mem [0:c_depth-1];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_old;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;
    logic                  w_err;
    logic [31:0]           w_merged;
    logic [31:0]           w_load;

    assign w_idx  = r_addr[ADDR_WIDTH+1:2];
    assign w_old  = r_mem[w_idx];
    assign w_half = r_addr[1] ? w_old[31:16] : w_old[15:0];

    always_comb begin
        w_byte = w_old[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = w_old[15:8];
            2'd2:    w_byte = w_old[23:16];
            2'd3:    w_byte = w_old[31:24];
            default: w_byte = w_old[7:0];
        endcase
    end

    // Ops 2 and 4 are the signed variants; op[1] flags signed half, op[2] signed byte.
    always_comb begin
        w_err    = 1'b0;
        w_merged = w_old;
        w_load   = 32'd0;
        case (r_op)
            3'd0: begin
                w_err    = (r_addr[1:0] != 2'd0);
                w_merged = r_wdata;
                w_load   = w_old;
            end
            3'd1, 3'd2: begin
                w_err    = r_addr[0];
                w_merged = r_addr[1] ? {r_wdata[15:0], w_old[15:0]}
                                     : {w_old[31:16], r_wdata[15:0]};
                w_load   = {{16{r_op[1] & w_half[15]}}, w_half};
            end
            3'd3, 3'd4: begin
                case (r_addr[1:0])
                    2'd0:    w_merged = {w_old[31:8], r_wdata[7:0]};
                    2'd1:    w_merged = {w_old[31:16], r_wdata[7:0], w_old[7:0]};
                    2'd2:    w_merged = {w_old[31:24], r_wdata[7:0], w_old[15:0]};
                    default: w_merged = {r_wdata[7:0], w_old[23:0]};
                endcase
                w_load = {{24{r_op[2] & w_byte[7]}}, w_byte};
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_op     <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wpc    <= 32'd0;
            Ready    <= 1'b1;
            RValid   <= 1'b0;
            RData    <= 32'd0;
            Err      <= 1'b0;
            LogValid <= 1'b0;
            LogPC    <= 32'd0;
            LogAddr  <= 32'd0;
            LogData  <= 32'd0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Req) begin
                        r_wr    <= Wr;
                        r_op    <= Op;
                        r_addr  <= Addr;
                        r_wdata <= WData;
                        r_wpc   <= WPC;
                        r_cnt   <= c_lat_init;
                        Ready   <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                        RValid  <= 1'b1;
                        Err     <= w_err;
                        RData   <= (!r_wr && !w_err) ? w_load : 32'd0;
                        if (r_wr && !w_err) begin
                            r_mem[w_idx] <= w_merged;
                            LogValid     <= 1'b1;
                            LogPC        <= r_wpc;
                            LogAddr      <= {r_addr[31:2], 2'b00};
                            LogData      <= w_merged;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    RValid   <= 1'b0;
                    LogValid <= 1'b0;
                    Ready    <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    Ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Directed plus randomized checks of dm_responder against a
//            lane/mask arithmetic memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_responder;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Rst, Req, Wr;
    logic [2:0]  Op;
    logic [31:0] Addr, WData, WPC;
    logic        Ready, RValid, Err, LogValid;
    logic [31:0] RData, LogPC, LogAddr, LogData;

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Op(Op), .Addr(Addr),
        .WData(WData), .WPC(WPC), .Ready(Ready), .RValid(RValid),
        .RData(RData), .Err(Err), .LogValid(LogValid), .LogPC(LogPC),
        .LogAddr(LogAddr), .LogData(LogData)
    );

    always #5 Clk = ~Clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl [0:(1<<AW)-1];
    logic [31:0] e_logpc, e_logaddr, e_logdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < (1<<AW); i++) mdl[i] = 32'd0;
        e_logpc = 0; e_logaddr = 0; e_logdata = 0;
    endtask

    // Called at a falling edge with the responder idle; returns at a falling edge.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] wpc);
        int          size, lane, sh, n;
        logic        e_err, e_logv, sgn;
        logic [31:0] mask, old, e_rdata, merged, v;
        size = (op == 0) ? 4 : (op <= 2) ? 2 : (op <= 4) ? 1 : 0;
        lane = int'(addr[1:0]);
        e_err = (size == 0) || ((lane % (size == 0 ? 1 : size)) != 0);
        sh   = 8 * lane;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        old  = mdl[addr[AW+1:2]];
        e_rdata = 32'd0;
        merged  = old;
        e_logv  = 1'b0;
        if (!e_err) begin
            if (wr) begin
                merged = (old & ~(mask << sh)) | ((wdata & mask) << sh);
                e_logv = 1'b1;
                e_logpc = wpc; e_logaddr = addr & 32'hFFFF_FFFC; e_logdata = merged;
            end else begin
                v   = (old >> sh) & mask;
                sgn = (op == 2) || (op == 4);
                if (sgn && v[8*size-1]) v = v | ~mask;
                e_rdata = v;
            end
        end

        Req = 1'b1; Wr = wr; Op = op; Addr = addr; WData = wdata; WPC = wpc;
        chk({tag, "_ready_idle"}, 32'(Ready), 32'd1);
        @(negedge Clk);
        Req = 1'b0;
        n = 1;
        chk({tag, "_ready_busy"}, 32'(Ready), 32'd0);
        while (!RValid && n < LAT + 8) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        chk({tag, "_err"}, 32'(Err), 32'(e_err));
        chk({tag, "_rdata"}, RData, e_rdata);
        chk({tag, "_logvalid"}, 32'(LogValid), 32'(e_logv));
        chk({tag, "_logpc"}, LogPC, e_logpc);
        chk({tag, "_logaddr"}, LogAddr, e_logaddr);
        chk({tag, "_logdata"}, LogData, e_logdata);
        if (wr && !e_err) mdl[addr[AW+1:2]] = merged;
        @(negedge Clk);
        chk({tag, "_rvalid_drop"}, 32'(RValid), 32'd0);
        chk({tag, "_ready_back"}, 32'(Ready), 32'd1);
    endtask

    initial begin
        int          pulses, cyc, last, issued;
        logic [31:0] q_exp [$];
        logic [2:0]  rop;
        logic [31:0] raddr;

        Rst = 1'b1; Req = 1'b0; Wr = 1'b0; Op = 3'd0; Addr = 0; WData = 0; WPC = 0;
        model_clear();
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;
        chk("rst_ready", 32'(Ready), 32'd1);
        chk("rst_rvalid", 32'(RValid), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_logvalid", 32'(LogValid), 32'd0);
        chk("rst_rdata", RData, 32'd0);
        chk("rst_logpc", LogPC, 32'd0);
        chk("rst_logaddr", LogAddr, 32'd0);
        chk("rst_logdata", LogData, 32'd0);

        do_req("sw_word", 1, 3'd0, 32'h10, 32'h1234_5678, 32'h3000);
        do_req("sb_13", 1, 3'd3, 32'h13, 32'h0000_00AB, 32'h3004);
        do_req("lb_13", 0, 3'd4, 32'h13, 32'h0, 32'h3008);
        do_req("lbu_13", 0, 3'd3, 32'h13, 32'h0, 32'h300C);
        do_req("lw_10", 0, 3'd0, 32'h10, 32'h0, 32'h3010);
        do_req("sh_12", 1, 3'd1, 32'h12, 32'h0000_8001, 32'h3014);
        do_req("lh_12", 0, 3'd2, 32'h12, 32'h0, 32'h3018);
        do_req("lhu_12", 0, 3'd1, 32'h12, 32'h0, 32'h301C);
        do_req("sw_mis", 1, 3'd0, 32'h11, 32'hFFFF_FFFF, 32'h3020);
        do_req("lw_after_mis", 0, 3'd0, 32'h10, 32'h0, 32'h3024);
        do_req("lh_mis", 0, 3'd1, 32'h13, 32'h0, 32'h3028);
        do_req("op6", 0, 3'd6, 32'h10, 32'h0, 32'h302C);
        chk("known_word", mdl[4], 32'h8001_5678);

        // Req held high across three back-to-back word loads.
        pulses = 0; cyc = 0; last = -1; issued = 0;
        q_exp.delete();
        while (pulses < 3 && cyc < 60) begin
            if (Ready && issued < 3) begin
                Req = 1'b1; Wr = 1'b0; Op = 3'd0;
                Addr = 32'h10 + 32'(4 * issued);
                q_exp.push_back(mdl[4 + issued]);
                issued++;
            end
            @(negedge Clk);
            cyc++;
            if (RValid) begin
                if (last >= 0) chk("hold_spacing", 32'(cyc - last), 32'(LAT + 2));
                chk("hold_rdata", RData, (q_exp.size() > 0) ? q_exp.pop_front() : 32'hDEAD_DEAD);
                last = cyc;
                pulses++;
            end
        end
        Req = 1'b0;
        repeat (LAT + 4) begin
            @(negedge Clk);
            if (RValid) pulses++;
        end
        chk("hold_pulses", 32'(pulses), 32'd3);

        // Req toggled only while busy must not start a second access.
        Req = 1'b1; Wr = 1'b0; Op = 3'd0; Addr = 32'h10;
        @(negedge Clk);
        pulses = 0;
        for (int k = 0; k < LAT + 1; k++) begin
            Req = ~Req;
            @(negedge Clk);
            if (RValid) pulses++;
        end
        Req = 1'b0;
        repeat (LAT + 5) begin
            @(negedge Clk);
            if (RValid) pulses++;
        end
        chk("toggle_pulses", 32'(pulses), 32'd1);

        // Reset one cycle after accepting a store aborts it.
        Req = 1'b1; Wr = 1'b1; Op = 3'd0; Addr = 32'h20; WData = 32'hDEAD_BEEF; WPC = 32'h4000;
        @(negedge Clk);
        Req = 1'b0; Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        model_clear();
        pulses = 0;
        repeat (LAT + 4) begin
            @(negedge Clk);
            if (RValid || LogValid) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        do_req("lw_20_after_abort", 0, 3'd0, 32'h20, 32'h0, 32'h4004);

        // Req coincident with reset is not accepted.
        Rst = 1'b1; Req = 1'b1; Wr = 1'b1; Op = 3'd0; Addr = 32'h24; WData = 32'h5555_AAAA;
        @(negedge Clk);
        Rst = 1'b0; Req = 1'b0;
        chk("rst_req_ready", 32'(Ready), 32'd1);
        pulses = 0;
        repeat (LAT + 4) begin
            @(negedge Clk);
            if (RValid) pulses++;
        end
        chk("rst_req_pulses", 32'(pulses), 32'd0);

        for (int r = 0; r < 40; r++) begin
            rop   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            raddr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
            do_req($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), rop, raddr, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
